// File: rtl/sorted_shift_pq.sv
// Register-based sorted priority queue: per-cell compare, single-cycle
// enqueue / dequeue / replace with tag payload and FIFO order among ties.
module sorted_shift_pq #(
    parameter int unsigned QUEUE_SIZE = 16,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned TAG_WIDTH  = 8,
    parameter int unsigned MIN_FIRST  = 0
) (
    input  logic                              CLK,
    input  logic                              RSTn,
    input  logic                              i_wrt,
    input  logic                              i_read,
    input  logic [DATA_WIDTH-1:0]             i_data,
    input  logic [TAG_WIDTH-1:0]              i_tag,
    output logic                              o_full,
    output logic                              o_empty,
    output logic [DATA_WIDTH-1:0]             o_data,
    output logic [TAG_WIDTH-1:0]              o_tag,
    output logic [$clog2(QUEUE_SIZE+1)-1:0]   o_count,
    output logic                              o_drop
);

    localparam int unsigned CW = $clog2(QUEUE_SIZE + 1);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] key;
        logic [TAG_WIDTH-1:0]  tag;
    } entry_t;

    typedef enum logic [2:0] {
        OP_IDLE,
        OP_ENQ,
        OP_DEQ,
        OP_REP,
        OP_DROP
    } op_e;

    entry_t                cell_q [QUEUE_SIZE];
    entry_t                cell_d [QUEUE_SIZE];
    entry_t                up     [QUEUE_SIZE];
    entry_t                dn     [QUEUE_SIZE];
    logic [CW-1:0]         count_q, count_d;
    logic                  drop_q, drop_d;
    logic [QUEUE_SIZE-1:0] ahead;
    logic [QUEUE_SIZE-1:0] ins_here;
    logic [QUEUE_SIZE-1:0] rep_next;
    logic [QUEUE_SIZE-1:0] rep_here;
    logic                  full, empty;
    entry_t                new_e;
    op_e                   op;

    assign full  = (count_q == CW'(QUEUE_SIZE));
    assign empty = (count_q == '0);
    assign new_e = '{key: i_data, tag: i_tag};

    always_comb begin
        op = OP_IDLE;
        unique case (1'b1)
            i_wrt && i_read:  op = empty ? OP_ENQ : OP_REP;
            i_wrt && !i_read: op = full ? OP_DROP : OP_ENQ;
            !i_wrt && i_read: op = empty ? OP_IDLE : OP_DEQ;
            default:          op = OP_IDLE;
        endcase
    end

    // Valid cells are sorted, so "ahead" is always a prefix of the array.
    always_comb begin
        ahead = '0;
        for (int i = 0; i < int'(QUEUE_SIZE); i++) begin
            if (count_q > CW'(i)) begin
                if (MIN_FIRST != 0)
                    ahead[i] = (cell_q[i].key <= i_data);
                else
                    ahead[i] = (cell_q[i].key >= i_data);
            end
        end
    end

    assign ins_here = {ahead[QUEUE_SIZE-2:0], 1'b1};
    assign rep_next = {1'b0, ahead[QUEUE_SIZE-1:1]};
    assign rep_here = {ahead[QUEUE_SIZE-1:1], 1'b1};

    always_comb begin
        up[0] = '0;
        for (int i = 1; i < int'(QUEUE_SIZE); i++)
            up[i] = cell_q[i-1];
        dn[QUEUE_SIZE-1] = '0;
        for (int i = 0; i < int'(QUEUE_SIZE) - 1; i++)
            dn[i] = cell_q[i+1];
    end

    always_comb begin
        count_d = count_q;
        drop_d  = 1'b0;
        for (int i = 0; i < int'(QUEUE_SIZE); i++)
            cell_d[i] = cell_q[i];
        unique case (op)
            OP_ENQ: begin
                count_d = count_q + CW'(1);
                for (int i = 0; i < int'(QUEUE_SIZE); i++) begin
                    if (!ahead[i])
                        cell_d[i] = ins_here[i] ? new_e : up[i];
                end
            end
            OP_DEQ: begin
                count_d = count_q - CW'(1);
                for (int i = 0; i < int'(QUEUE_SIZE); i++)
                    cell_d[i] = dn[i];
            end
            OP_REP: begin
                for (int i = 0; i < int'(QUEUE_SIZE); i++) begin
                    if (rep_next[i])
                        cell_d[i] = dn[i];
                    else if (rep_here[i])
                        cell_d[i] = new_e;
                end
            end
            OP_DROP: drop_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            for (int i = 0; i < int'(QUEUE_SIZE); i++)
                cell_q[i] <= '0;
            count_q <= '0;
            drop_q  <= 1'b0;
        end else begin
            for (int i = 0; i < int'(QUEUE_SIZE); i++)
                cell_q[i] <= cell_d[i];
            count_q <= count_d;
            drop_q  <= drop_d;
        end
    end

    assign o_full  = full;
    assign o_empty = empty;
    assign o_data  = cell_q[0].key;
    assign o_tag   = cell_q[0].tag;
    assign o_count = count_q;
    assign o_drop  = drop_q;

endmodule

// File: tb/tb_sorted_shift_pq.sv
// Bench for sorted_shift_pq: vector table, directed corners, and random
// traffic on a max-first and a min-first instance against a list model.
module tb_sorted_shift_pq;

    localparam int N = 16;

    logic        CLK;
    logic        RSTn;
    logic        wrt     [2];
    logic        rd      [2];
    logic [15:0] din     [2];
    logic [7:0]  tin     [2];
    logic        full_o  [2];
    logic        empty_o [2];
    logic        drop_o  [2];
    logic [15:0] data_o  [2];
    logic [7:0]  tag_o   [2];
    logic [4:0]  cnt_o   [2];

    int n_chk;
    int n_fail;

    sorted_shift_pq #(.MIN_FIRST(0)) u_max (
        .CLK(CLK), .RSTn(RSTn),
        .i_wrt(wrt[0]), .i_read(rd[0]),
        .i_data(din[0]), .i_tag(tin[0]),
        .o_full(full_o[0]), .o_empty(empty_o[0]),
        .o_data(data_o[0]), .o_tag(tag_o[0]),
        .o_count(cnt_o[0]), .o_drop(drop_o[0])
    );

    sorted_shift_pq #(.MIN_FIRST(1)) u_min (
        .CLK(CLK), .RSTn(RSTn),
        .i_wrt(wrt[1]), .i_read(rd[1]),
        .i_data(din[1]), .i_tag(tin[1]),
        .o_full(full_o[1]), .o_empty(empty_o[1]),
        .o_data(data_o[1]), .o_tag(tag_o[1]),
        .o_count(cnt_o[1]), .o_drop(drop_o[1])
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Model: entries of both instances kept in arrival order in one list.
    typedef struct {
        int inst;
        int key;
        int tag;
    } ent_t;

    ent_t mq[$];
    bit   mdrop[2];

    function automatic int msize(int inst);
        int n = 0;
        foreach (mq[i]) if (mq[i].inst == inst) n++;
        return n;
    endfunction

    // Best key wins; strict compare keeps the oldest among equal keys.
    function automatic int mhead(int inst);
        int b = -1;
        foreach (mq[i]) begin
            if (mq[i].inst == inst) begin
                if (b < 0)
                    b = i;
                else if (inst == 1 && mq[i].key < mq[b].key)
                    b = i;
                else if (inst == 0 && mq[i].key > mq[b].key)
                    b = i;
            end
        end
        return b;
    endfunction

    task automatic model_op(int inst, bit w, bit r, int k, int t);
        int n = msize(inst);
        ent_t e;
        e.inst = inst;
        e.key = k;
        e.tag = t;
        mdrop[inst] = 1'b0;
        if (w && !r) begin
            if (n == N) mdrop[inst] = 1'b1;
            else mq.push_back(e);
        end else if (r && !w) begin
            if (n > 0) mq.delete(mhead(inst));
        end else if (w && r) begin
            if (n > 0) mq.delete(mhead(inst));
            mq.push_back(e);
        end
    endtask

    task automatic chk(string nm, int inst, int got, int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s inst%0d: got %0d expected %0d",
                     nm, inst, got, exp);
        end
    endtask

    task automatic check_inst(int inst);
        int h = mhead(inst);
        int n = msize(inst);
        chk("data", inst, int'(data_o[inst]), (h < 0) ? 0 : mq[h].key);
        chk("tag", inst, int'(tag_o[inst]), (h < 0) ? 0 : mq[h].tag);
        chk("count", inst, int'(cnt_o[inst]), n);
        chk("empty", inst, int'(empty_o[inst]), int'(n == 0));
        chk("full", inst, int'(full_o[inst]), int'(n == N));
        chk("drop", inst, int'(drop_o[inst]), int'(mdrop[inst]));
    endtask

    task automatic op(int inst, bit w, bit r, int k, int t);
        wrt[inst] = w;
        rd[inst]  = r;
        din[inst] = 16'(k);
        tin[inst] = 8'(t);
        @(posedge CLK);
        #1;
        wrt[inst] = 1'b0;
        rd[inst]  = 1'b0;
        model_op(inst, w, r, k, t);
        check_inst(inst);
    endtask

    typedef struct {
        bit w;
        bit r;
        int k;
        int t;
        int ed;
        int et;
        int ec;
    } vec_t;

    vec_t tbl[14];

    initial begin
        tbl[0]  = '{1, 0, 5,   1, 5,   1, 1};
        tbl[1]  = '{1, 0, 900, 3, 900, 3, 2};
        tbl[2]  = '{1, 0, 42,  2, 900, 3, 3};
        tbl[3]  = '{1, 0, 900, 7, 900, 3, 4};
        tbl[4]  = '{0, 1, 0,   0, 900, 7, 3};
        tbl[5]  = '{0, 1, 0,   0, 42,  2, 2};
        tbl[6]  = '{0, 1, 0,   0, 5,   1, 1};
        tbl[7]  = '{0, 1, 0,   0, 0,   0, 0};
        tbl[8]  = '{0, 1, 0,   0, 0,   0, 0};
        tbl[9]  = '{1, 1, 77,  9, 77,  9, 1};
        tbl[10] = '{0, 1, 0,   0, 0,   0, 0};
        tbl[11] = '{1, 0, 3,   4, 3,   4, 1};
        tbl[12] = '{1, 1, 3,   5, 3,   5, 1};
        tbl[13] = '{0, 1, 0,   0, 0,   0, 0};

        n_chk  = 0;
        n_fail = 0;
        mdrop[0] = 1'b0;
        mdrop[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wrt[i] = 1'b0;
            rd[i]  = 1'b0;
            din[i] = '0;
            tin[i] = '0;
        end
        RSTn = 1'b0;
        #12;
        check_inst(0);
        check_inst(1);
        RSTn = 1'b1;
        @(posedge CLK);
        #1;

        for (int i = 0; i < 14; i++) begin
            op(0, tbl[i].w, tbl[i].r, tbl[i].k, tbl[i].t);
            chk("tbl_data", 0, int'(data_o[0]), tbl[i].ed);
            chk("tbl_tag", 0, int'(tag_o[0]), tbl[i].et);
            chk("tbl_count", 0, int'(cnt_o[0]), tbl[i].ec);
            chk("tbl_empty", 0, int'(empty_o[0]), int'(tbl[i].ec == 0));
            chk("tbl_drop", 0, int'(drop_o[0]), 0);
        end

        for (int i = 0; i < N; i++)
            op(0, 1'b1, 1'b0, int'($urandom_range(0, 999)), i);
        chk("fill_full", 0, int'(full_o[0]), 1);
        op(0, 1'b1, 1'b0, 1000, 200);
        chk("full_drop", 0, int'(drop_o[0]), 1);
        chk("full_count", 0, int'(cnt_o[0]), N);
        op(0, 1'b1, 1'b1, 1000, 170);
        chk("rep_full_data", 0, int'(data_o[0]), 1000);
        chk("rep_full_tag", 0, int'(tag_o[0]), 170);
        chk("rep_full_count", 0, int'(cnt_o[0]), N);
        chk("rep_full_drop", 0, int'(drop_o[0]), 0);

        for (int i = 0; i < 20; i++)
            op(0, 1'b1, 1'b1, int'($urandom_range(0, 1024)), i + 30);

        for (int i = 0; i < 300; i++)
            op(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 15)), i & 255);

        for (int i = 0; i < N && msize(0) > 0; i++)
            op(0, 1'b0, 1'b1, 0, 0);
        for (int i = 0; i < 8; i++)
            op(0, 1'b1, 1'b0, 100 + i * 7, i);
        chk("pre_rst_count", 0, int'(cnt_o[0]), 8);

        wrt[0] = 1'b1;
        din[0] = 16'd55;
        RSTn = 1'b0;
        #2;
        mq.delete();
        mdrop[0] = 1'b0;
        mdrop[1] = 1'b0;
        check_inst(0);
        check_inst(1);
        @(posedge CLK);
        #1;
        check_inst(0);
        wrt[0] = 1'b0;
        RSTn = 1'b1;
        op(0, 1'b1, 1'b0, 9, 1);
        chk("post_rst_data", 0, int'(data_o[0]), 9);
        chk("post_rst_count", 0, int'(cnt_o[0]), 1);

        op(1, 1'b1, 1'b0, 30, 1);
        op(1, 1'b1, 1'b0, 10, 2);
        op(1, 1'b1, 1'b0, 20, 3);
        chk("min_head", 1, int'(data_o[1]), 10);
        op(1, 1'b1, 1'b1, 25, 4);
        chk("min_rep", 1, int'(data_o[1]), 20);
        op(1, 1'b0, 1'b1, 0, 0);
        chk("min_deq1", 1, int'(data_o[1]), 25);
        op(1, 1'b0, 1'b1, 0, 0);
        chk("min_deq2", 1, int'(data_o[1]), 30);

        for (int i = 0; i < 200; i++)
            op(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 20)), i & 255);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sorted_shift_pq.md
Name: sorted_shift_pq

Overview:
- Parametrised, register-based priority queue; next generation of the hybrid tree queue.
- Adds a per-entry tag payload, selectable max-first/min-first ordering, FIFO ordering among equal keys, an occupancy count, and a drop indication.
- Supports single-cycle enqueue, dequeue and replace, back-to-back every cycle, with no busy or settle period.
- Sits beside the tree queues as a low-latency front stage or small standalone scheduler.

Parameters:
- QUEUE_SIZE, 16: number of entries; must be ≥ 2.
- DATA_WIDTH, 16: key width; keys are unsigned.
- TAG_WIDTH, 8: width of the payload carried with each key.
- MIN_FIRST, 0: 0 puts the largest key at the head; 1 puts the smallest key at the head.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RSTn  input  1  asynchronous active-low reset.
- i_wrt  input  1  insert i_data/i_tag this cycle.
- i_read  input  1  remove the head this cycle. i_wrt and i_read together means replace.
- i_data  input  DATA_WIDTH  key to insert.
- i_tag  input  TAG_WIDTH  payload to insert.
- o_full  output  1  count == QUEUE_SIZE.
- o_empty  output  1  count == 0.
- o_data  output  DATA_WIDTH  key at the head; 0 when empty.
- o_tag  output  TAG_WIDTH  tag at the head; 0 when empty.
- o_count  output  $clog2(QUEUE_SIZE+1)  current occupancy.
- o_drop  output  1  one-cycle pulse: an enqueue was rejected because the queue was full.

Behaviour:
- Storage:
  - Cells 0..QUEUE_SIZE-1 hold {key, tag}. Cell 0 is the head.
  - Valid entries are cells 0..count-1, kept sorted.
  - Cells at index ≥ count hold zero.
- "Ahead of new key" relation:
  - MIN_FIRST=0: cell key ≥ new key.
  - MIN_FIRST=1: cell key ≤ new key.
  - Equal keys rank the older entry first (FIFO among ties).
- Reset (async assert, sync release):
  - All cells 0, count 0.
  - o_empty=1, o_full=0, o_drop=0, o_data=0, o_tag=0.
  - Reset during any operation discards it fully; no partial shift survives.
- Outputs:
  - All outputs are registered or decoded from registers.
  - An operation sampled at edge k is visible on the outputs right after edge k (one-cycle latency).
  - A new operation may be issued on every edge.
- Enqueue (i_wrt=1, i_read=0, count < QUEUE_SIZE):
  - p = number of valid cells ahead of the new key.
  - cell[i] keeps its value for i < p; cell[p] = new; cell[i] = old cell[i-1] for p < i ≤ count.
  - count+1.
- Enqueue when full:
  - Cells and count unchanged.
  - o_drop=1 for exactly the following cycle.
- Dequeue (i_read=1, i_wrt=0, count > 0):
  - cell[i] = old cell[i+1] for i < count-1; cell[count-1] = 0.
  - count-1.
- Dequeue when empty: no state change, no drop.
- Replace (both set, count > 0):
  - p = number of cells among 1..count-1 ahead of the new key.
  - cell[i] = old cell[i+1] for i < p; cell[p] = new; cells above p unchanged.
  - count unchanged. Legal when full; never drops.
- Replace when empty: behaves as an enqueue.
- Idle (neither set): state holds; o_drop=0.
- o_drop is deasserted on every cycle except the one following a rejected enqueue.
- Comparison uses one comparator per cell in parallel (no iterative search). The position computation must close timing combinationally within one cycle at default parameters.

Test Plan:
- Reset, then enqueue keys 5, 900, 42, 900(tag 7 after tag 3): with MIN_FIRST=0, successive dequeues return 900/3, 900/7, 42, 5; o_count 4→0; o_empty=1 after the last dequeue.
- Fill 16 entries, then enqueue 1000 → o_full=1, o_drop high for one cycle, head unchanged. A following replace with 1000 → head 1000, o_count stays 16, o_drop=0.
- Twenty random replaces (keys 0..1024) with a reference model pop-head/push/sort → o_data matches the model head after every edge, issued with no idle cycles between operations.
- MIN_FIRST=1 instance: enqueue 30, 10, 20 → o_data 10. Replace with 25 → o_data 20. Dequeue → 25. Dequeue → 30.
- Dequeue on empty, and replace on empty with 77 → first: no change; second: o_count=1, o_data=77.
- Assert RSTn low mid-sequence with 8 entries → outputs immediately 0/empty; after release, enqueue 9 → o_data=9, o_count=1.
